load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Downstream neighbour of the single-cycle datapath. Consumes its ALUResult (address) and WD (store data),
//  runs a req/ack transaction on the external data-memory bus, and returns formatted read data on RD.
//  Handles byte/halfword lane steering, load sign/zero extension, misalignment faults and a bus timeout.
//  Holds the core with Stall while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max WAIT cycles without mem_ack before abort; 1..2^TO_W-1
//  TO_W            8    width of timeout counter
// PORTS
//  clk          in   1   rising-edge clock, single clock domain
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  MemRead      in   1   current instruction is a load
//  MemWrite     in   1   current instruction is a store
//  funct3       in   3   Instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResult    in   32  byte address from datapath
//  WD           in   32  store data (RD2) from datapath
//  RD           out  32  formatted load data to datapath Result_Mux
//  Stall        out  1   1 = hold PC and suppress RegWrite this cycle
//  MemFault     out  1   one-cycle pulse: misaligned, illegal funct3, R+W both set, or timeout
//  mem_req      out  1   bus request, held until ack cycle inclusive
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word address {ALUResult[31:2],2'b00}
//  mem_be       out  4   byte enables (writes); 4'b1111 on reads
//  mem_wdata    out  32  lane-replicated store data
//  mem_rdata    in   32  bus read word, valid with mem_ack
//  mem_ack      in   1   bus completion strobe; ignored unless mem_req=1
// BEHAVIOUR
//  Reset: state=IDLE; RD=0, Stall=0, MemFault=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, counter=0.
//  FSM states: IDLE, WAIT, DONE.
//  IDLE: access = MemRead|MemWrite. Legal access -> Stall=1 combinationally same cycle; at edge latch addr/be/wdata/
//   funct3/lane, mem_req<=1, counter<=0, -> WAIT. No access -> stay, Stall=0.
//  Illegal access (H with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111; MemRead&MemWrite): no bus cycle,
//   Stall=0, MemFault=1 for that cycle, RD=0, state stays IDLE. Core retires instruction; write lost.
//  WAIT: Stall=1; bus outputs stable. mem_ack=1 -> load: RD<=formatted mem_rdata; store: RD unchanged;
//   mem_req<=0, -> DONE. Else counter++; counter==TIMEOUT_CYCLES-1 without ack -> mem_req<=0, RD<=0,
//   MemFault pulses in DONE cycle, -> DONE.
//  DONE: Stall=0, RD stable; core retires at this edge; -> IDLE unconditionally (next instr seen in IDLE).
//  Latency: ack in first WAIT cycle -> instruction takes 3 cycles; each extra WAIT cycle adds 1.
//  Store formatting: SB wdata={4{WD[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{WD[15:0]}}, be=4'b0011<<addr[1:0];
//   SW wdata=WD, be=4'b1111.
//  Load formatting: byte lane = rdata[8*addr[1:0]+:8], half lane = rdata[16*addr[1]+:16];
//   B/H sign-extend, BU/HU zero-extend, W passthrough.
//  mem_ack while IDLE/DONE or mem_req=0: ignored. Ack and timeout same cycle: ack wins, no fault.
//  reset asserted mid-WAIT: immediate return to IDLE, mem_req drops asynchronously; bus must drop a pending ack.
//  Inputs MemRead/MemWrite/ALUResult/WD changing during WAIT: ignored (latched values used).
// STRUCTURE
//  riscv_pkg: funct3 load/store constants (F3_B,F3_H,F3_W,F3_BU,F3_HU), LSU state encoding, TIMEOUT default.
//  Sub-module lsu_align (combinational): {funct3, addr[1:0], WD, rdata} -> {be, wdata, formatted rdata, misaligned}.
//  Top: FSM, timeout counter, latched bus registers, RD register.
// TESTING
//  1 SW addr=0x100 WD=0xDEADBEEF, ack 1st WAIT cycle -> mem_we=1 be=1111 wdata=DEADBEEF, Stall 1,1,0; 3 cycles.
//  2 mem_rdata=0x80FF7F01: LB @0x103 -> RD=0xFFFFFF80; LBU @0x103 -> 0x00000080; LH @0x102 -> 0xFFFF80FF;
//    LHU @0x100 -> 0x00007F01.
//  3 SB addr=0x201 WD=0x000000AB -> be=0010 wdata=0xABABABAB; SH addr=0x202 WD=0x1234 -> be=1100 wdata=0x12341234.
//  4 LW addr=0x102; SH addr=0x203; funct3=011; MemRead=MemWrite=1 -> MemFault 1 cycle, Stall=0, mem_req stays 0, RD=0.
//  5 LW with no ack, TIMEOUT_CYCLES=4 -> 4 WAIT cycles, mem_req drops, DONE with MemFault=1 RD=0; late ack ignored.
//  6 reset low during WAIT (cycle 2 of 5-cycle ack delay) -> mem_req=0 and all outputs 0 immediately; next LW clean.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: load/store funct3 codes, LSU state encoding and bus timeout default.
package riscv_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam int TIMEOUT_DEFAULT = 255;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;
   function automatic logic f3_legal(input logic [2:0] f3);
      return f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU;
   endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: req/ack data-memory bus between the LSU (master) and memory (slave).
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
   modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and sign/zero-extending formatting for loads.
module lsu_align (
   input  logic [2:0]  f3,
   input  logic [1:0]  lane,
   input  logic [31:0] wd,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] rdata_fmt,
   output logic        misaligned
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b          = rdata[{lane, 3'b000} +: 8];
      h          = rdata[{lane[1], 4'b0000} +: 16];
      be         = f3[1:0] == 2'b00 ? 4'b0001 << lane : f3[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
      wdata      = f3[1:0] == 2'b00 ? {4{wd[7:0]}} : f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
      rdata_fmt  = f3[1:0] == 2'b00 ? {{24{b[7] & ~f3[2]}}, b} :
                   f3[1:0] == 2'b01 ? {{16{h[15] & ~f3[2]}}, h} : rdata;
      misaligned = (f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != 2'b00);
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: runs one req/ack data-memory transaction per load/store, stalling the core meanwhile.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int TO_W           = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        Stall,
   output logic        MemFault,
   load_store_unit_if.master bus
);
   lsu_state_t      state_q, state_d;
   logic [2:0]      f3_q, f3_sel;
   logic [1:0]      lane_q, lane_sel;
   logic [TO_W-1:0] cnt_q;
   logic            to_q;
   logic [31:0]     rd_q;
   logic [3:0]      be;
   logic [31:0]     wdata, rdata_fmt;
   logic            misaligned, access, illegal, start, ack, timeout, bad_now;
   // Alignment uses live inputs while idle and the latched request while waiting.
   lsu_align u_align (
      .f3(f3_sel), .lane(lane_sel), .wd(WD), .rdata(bus.mem_rdata),
      .be(be), .wdata(wdata), .rdata_fmt(rdata_fmt), .misaligned(misaligned)
   );
   always_comb begin
      f3_sel   = state_q == IDLE ? funct3 : f3_q;
      lane_sel = state_q == IDLE ? ALUResult[1:0] : lane_q;
      access   = MemRead | MemWrite;
      illegal  = access & ((MemRead & MemWrite) | ~f3_legal(funct3) | misaligned);
      start    = access & ~illegal;
      ack      = bus.mem_ack & bus.mem_req;
      timeout  = ~ack & (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
      state_d  = state_q == IDLE ? (start ? WAIT : IDLE) :
                 state_q == WAIT ? ((ack | timeout) ? DONE : WAIT) : IDLE;
      bad_now  = reset & (state_q == IDLE) & illegal;
      Stall    = reset & ((state_q == WAIT) | ((state_q == IDLE) & start));
      MemFault = bad_now | (reset & (state_q == DONE) & to_q);
      RD       = bad_now ? 32'h0 : rd_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         f3_q          <= '0;
         lane_q        <= '0;
         cnt_q         <= '0;
         to_q          <= 1'b0;
         rd_q          <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_be    <= '0;
         bus.mem_wdata <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            f3_q          <= funct3;
            lane_q        <= ALUResult[1:0];
            cnt_q         <= '0;
            to_q          <= 1'b0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= MemWrite;
            bus.mem_addr  <= {ALUResult[31:2], 2'b00};
            bus.mem_be    <= MemWrite ? be : 4'b1111;
            bus.mem_wdata <= wdata;
         end else if (state_q == IDLE && illegal) begin
            rd_q <= '0;
         end else if (state_q == WAIT) begin
            if (ack) begin
               bus.mem_req <= 1'b0;
               if (!bus.mem_we) rd_q <= rdata_fmt;
            end else if (timeout) begin
               bus.mem_req <= 1'b0;
               rd_q        <= '0;
               to_q        <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of stores, loads, faults, timeout and mid-transaction reset.
module tb_load_store_unit;
   import riscv_pkg::*;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] ALUResult = '0, WD = '0;
   logic [31:0] RD;
   logic        Stall, MemFault;
   int          n_chk = 0, n_fail = 0;
   load_store_unit_if bus();
   load_store_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
      .ALUResult(ALUResult), .WD(WD), .RD(RD), .Stall(Stall), .MemFault(MemFault), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      MemRead = r; MemWrite = w; funct3 = f3; ALUResult = a; WD = d;
      #1;
   endtask
   task automatic idle_in();
      MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000; ALUResult = 32'hFFFF_FFFF; WD = 32'hFFFF_FFFF;
   endtask
   task automatic ack_now(input logic [31:0] d);
      bus.mem_rdata = d; bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
   endtask
   task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp, input string tag);
      issue(1'b1, 1'b0, f3, a, 32'h0);
      step();
      idle_in();
      ack_now(d);
      chk(tag, RD, exp);
      step();
   endtask
   initial begin
      bus.mem_rdata = '0; bus.mem_ack = 1'b0;
      #2;
      chk("rst_rd", RD, 32'h0);
      chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
      chk("rst_be", {28'h0, bus.mem_be}, 32'h0);
      chk("rst_flags", {30'h0, Stall, MemFault}, 32'h0);
      step(); step();
      reset = 1'b1;
      step();
      // 1: SW with ack in first WAIT cycle
      issue(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF);
      chk("sw_stall_c1", {31'h0, Stall}, 32'h1);
      step();
      idle_in();
      #1;
      chk("sw_stall_c2", {31'h0, Stall}, 32'h1);
      chk("sw_req", {31'h0, bus.mem_req}, 32'h1);
      chk("sw_we", {31'h0, bus.mem_we}, 32'h1);
      chk("sw_addr", bus.mem_addr, 32'h100);
      chk("sw_be", {28'h0, bus.mem_be}, 32'hF);
      chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
      ack_now(32'h0);
      chk("sw_stall_c3", {31'h0, Stall}, 32'h0);
      chk("sw_req_done", {31'h0, bus.mem_req}, 32'h0);
      chk("sw_rd_keep", RD, 32'h0);
      step();
      chk("sw_idle_stall", {31'h0, Stall}, 32'h0);
      // 2: load formatting
      load(F3_B,  32'h103, 32'h80FF7F01, 32'hFFFFFF80, "lb");
      load(F3_BU, 32'h103, 32'h80FF7F01, 32'h00000080, "lbu");
      load(F3_H,  32'h102, 32'h80FF7F01, 32'hFFFF80FF, "lh");
      load(F3_HU, 32'h100, 32'h80FF7F01, 32'h00007F01, "lhu");
      // 3: sub-word stores
      issue(1'b0, 1'b1, F3_B, 32'h201, 32'h000000AB);
      step();
      idle_in();
      #1;
      chk("sb_be", {28'h0, bus.mem_be}, 32'h2);
      chk("sb_wdata", bus.mem_wdata, 32'hABABABAB);
      chk("sb_addr", bus.mem_addr, 32'h200);
      ack_now(32'h0);
      chk("sb_rd_keep", RD, 32'h00007F01);
      step();
      issue(1'b0, 1'b1, F3_H, 32'h202, 32'h00001234);
      step();
      idle_in();
      #1;
      chk("sh_be", {28'h0, bus.mem_be}, 32'hC);
      chk("sh_wdata", bus.mem_wdata, 32'h12341234);
      ack_now(32'h0);
      step();
      // 4: illegal accesses fault without a bus cycle
      issue(1'b1, 1'b0, F3_W, 32'h102, 32'h0);
      chk("lw_mis_fault", {31'h0, MemFault}, 32'h1);
      chk("lw_mis_stall", {31'h0, Stall}, 32'h0);
      chk("lw_mis_rd", RD, 32'h0);
      step();
      chk("lw_mis_req", {31'h0, bus.mem_req}, 32'h0);
      issue(1'b0, 1'b1, F3_H, 32'h203, 32'h5555);
      chk("sh_mis_fault", {31'h0, MemFault}, 32'h1);
      chk("sh_mis_stall", {31'h0, Stall}, 32'h0);
      step();
      chk("sh_mis_req", {31'h0, bus.mem_req}, 32'h0);
      issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
      chk("f3_bad_fault", {31'h0, MemFault}, 32'h1);
      step();
      issue(1'b1, 1'b1, F3_W, 32'h100, 32'h0);
      chk("rw_fault", {31'h0, MemFault}, 32'h1);
      chk("rw_stall", {31'h0, Stall}, 32'h0);
      step();
      chk("rw_req", {31'h0, bus.mem_req}, 32'h0);
      idle_in();
      #1;
      chk("fault_clear", {31'h0, MemFault}, 32'h0);
      chk("fault_rd", RD, 32'h0);
      // 5: timeout after 4 WAIT cycles
      load(F3_W, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D, "lw_pre_to");
      issue(1'b1, 1'b0, F3_W, 32'h300, 32'h0);
      step();
      idle_in();
      step(); step(); step();
      chk("to_req_w4", {31'h0, bus.mem_req}, 32'h1);
      chk("to_stall_w4", {31'h0, Stall}, 32'h1);
      chk("to_fault_w4", {31'h0, MemFault}, 32'h0);
      step();
      chk("to_req_done", {31'h0, bus.mem_req}, 32'h0);
      chk("to_fault", {31'h0, MemFault}, 32'h1);
      chk("to_rd", RD, 32'h0);
      chk("to_stall", {31'h0, Stall}, 32'h0);
      bus.mem_rdata = 32'h99999999; bus.mem_ack = 1'b1;
      step();
      chk("late_fault", {31'h0, MemFault}, 32'h0);
      step();
      chk("late_rd", RD, 32'h0);
      chk("late_stall", {31'h0, Stall}, 32'h0);
      bus.mem_ack = 1'b0;
      // 6: reset in the middle of a slow transaction
      load(F3_W, 32'h108, 32'h11223344, 32'h11223344, "lw_pre_rst");
      issue(1'b1, 1'b0, F3_W, 32'h400, 32'h0);
      step();
      idle_in();
      step();
      #1;
      reset = 1'b0;
      #1;
      chk("mrst_req", {31'h0, bus.mem_req}, 32'h0);
      chk("mrst_rd", RD, 32'h0);
      chk("mrst_addr", bus.mem_addr, 32'h0);
      chk("mrst_flags", {30'h0, Stall, MemFault}, 32'h0);
      step();
      reset = 1'b1;
      issue(1'b1, 1'b0, F3_W, 32'h404, 32'h0);
      step();
      idle_in();
      #1;
      chk("post_addr", bus.mem_addr, 32'h404);
      step();
      chk("post_stall", {31'h0, Stall}, 32'h1);
      ack_now(32'h55667788);
      chk("post_rd", RD, 32'h55667788);
      chk("post_fault", {31'h0, MemFault}, 32'h0);
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
